challengeqsys_nios2_gen2_0_cpu_debug_ocimem: RTL and testbench
==============================================================

CHALLENGEQSYS_NIOS2_GEN2_0_CPU_DEBUG_OCIMEM -- requirements
Module: challengeqsys_nios2_gen2_0_cpu_debug_ocimem

Interface
REQ-001 SHALL have parameter DEPTH, default 256: debug RAM depth in 32-bit words; must be a power of 2.
REQ-002 SHALL have parameter AW, default 8: word-address width, equal to log2(DEPTH).
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-004 clk  in  1  sole clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 jdo  in  38  JTAG data word from the debug-slave sysclk stage.
REQ-007 take_action_ocimem_a  in  1  one-cycle strobe: load address, with optional read.
REQ-008 take_no_action_ocimem_a  in  1  one-cycle strobe: increment address, then read.
REQ-009 take_action_ocimem_b  in  1  one-cycle strobe: JTAG write at the current address.
REQ-010 address  in  AW  CPU word address.
REQ-011 read / write  in  1 each  CPU access requests; they are never asserted together.
REQ-012 writedata  in  32  CPU write data.
REQ-013 byteenable  in  4  CPU byte lanes.
REQ-014 readdata  out  32  CPU read data; valid in the cycle waitrequest is low during a read.
REQ-015 waitrequest  out  1  CPU stall.
REQ-016 MonDReg  out  32  monitor data register returned to the JTAG stage.
REQ-017 monitor_ready  out  1  MonDReg holds fresh JTAG read data.
REQ-018 monitor_error  out  1  sticky JTAG protocol error.

Function
REQ-019 SHALL contain one DEPTH x 32 RAM with a registered read port: data appears 1 cycle after the address is presented.
REQ-020 SHALL hold an AW-bit register MonAReg; every increment wraps from DEPTH-1 to 0.
REQ-021 SHALL implement FSM states IDLE, JRD (JTAG read in flight) and CRD (CPU read in flight).
REQ-022 On take_action_ocimem_a:
  - MonAReg <= jdo[AW+25:26] and monitor_ready <= 0.
  - If jdo[35]=1, the FSM enters JRD and reads RAM[jdo[AW+25:26]].
  - If jdo[25]=1, monitor_error <= 0.
REQ-023 On take_no_action_ocimem_a: MonAReg <= MonAReg+1, monitor_ready <= 0, and the FSM enters JRD reading RAM[MonAReg+1].
REQ-024 On take_action_ocimem_b: RAM[MonAReg] <= jdo[34:3] (all bytes), then MonAReg <= MonAReg+1; no read is issued.
REQ-025 From JRD, the FSM returns to IDLE on the next cycle, loading MonDReg with RAM data and setting monitor_ready <= 1 (latency 2 cycles from the strobe).
REQ-026 A JTAG strobe arriving while in JRD SHALL set monitor_error <= 1 and is otherwise ignored.
REQ-027 If two or more ocimem strobes are asserted in the same cycle:
  - Priority is a > no_action_a > b; the lower-priority strobes are dropped.
  - monitor_error <= 1.
REQ-028 CPU write in IDLE with no JTAG strobe:
  - Completes in that cycle with waitrequest=0.
  - Only the byte lanes selected by byteenable are written.
REQ-029 CPU read in IDLE with no JTAG strobe:
  - waitrequest=1 and the FSM enters CRD.
  - In CRD, waitrequest=0 and readdata=RAM[address]; the FSM returns to IDLE.
  - This gives 1 wait state.
REQ-030 JTAG has priority: any CPU request SHALL see waitrequest=1 in any cycle with a JTAG strobe or while in JRD; the CPU request stays pending and is not lost.
REQ-031 A JTAG strobe arriving while in CRD SHALL be serviced in the next cycle, after CRD completes; it is not dropped and no error is raised.
REQ-032 waitrequest SHALL be 0 whenever read=0 and write=0.
REQ-033 RAM contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-034 While reset=1, the block SHALL drive MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, readdata=0 and FSM=IDLE.
REQ-035 Reset asserted in JRD or CRD SHALL abort the operation: no MonDReg update, and the FSM is in IDLE in the cycle after reset deasserts.
REQ-036 JTAG strobes and CPU requests sampled while reset=1 SHALL be ignored.

Verification
REQ-037 JTAG write/read: action_a with jdo[33:26]=0x10 and jdo[35]=0, then action_b with jdo[34:3]=0xDEADBEEF, then action_a with jdo[33:26]=0x10 and jdo[35]=1 -> 2 cycles later MonDReg=0xDEADBEEF and monitor_ready=1; MonAReg=0x10.
REQ-038 Streaming with wrap: MonAReg=0xFF; take_no_action_ocimem_a -> MonAReg=0x00 and MonDReg=RAM[0] after 2 cycles.
REQ-039 Byte-lane write: CPU write to address 0x05 with writedata 0x11223344 and byteenable 4'b0101 over RAM[5]=0xAABBCCDD -> a CPU read returns 0xAA22CC44 with exactly one waitrequest cycle.
REQ-040 Contention and errors:
  - CPU read held while action_a (jdo[35]=1) fires -> waitrequest stays high through JRD, then CRD completes with correct data.
  - Simultaneous action_a and action_b -> monitor_error=1 and the RAM is unchanged.
REQ-041 Mid-operation reset: reset pulsed in the cycle after a JTAG read strobe -> MonDReg=0, monitor_ready=0 and FSM=IDLE; a subsequent read returns the correct RAM data.

Source files
------------

// File: rtl/challengeqsys_nios2_gen2_0_cpu_debug_ocimem.sv
// ---------------------------------------------------------------------------
// challengeqsys_nios2_gen2_0_cpu_debug_ocimem
//
// On-chip debug memory shared by the JTAG debug path and the CPU.
//
// One DEPTH x 32 RAM with a registered read port. The JTAG side reaches it
// through an auto-incrementing address register (MonAReg) and a monitor data
// register (MonDReg). The CPU side is a simple Avalon-style slave with
// waitrequest. JTAG always has priority over the CPU.
//
// Ports
//   clk, reset                 sole clock, synchronous active-high reset
//   jdo[37:0]                  JTAG data word (addr [AW+25:26], read [35],
//                              clear-error [25], write data [34:3])
//   take_action_ocimem_a       strobe: load MonAReg, optional read
//   take_no_action_ocimem_a    strobe: increment MonAReg, then read
//   take_action_ocimem_b       strobe: write RAM[MonAReg], then increment
//   address, read, write,
//   writedata, byteenable      CPU request
//   readdata, waitrequest      CPU response (1 wait state on reads)
//   MonDReg, monitor_ready     JTAG read data and its freshness flag
//   monitor_error              sticky JTAG protocol error
// ---------------------------------------------------------------------------
module challengeqsys_nios2_gen2_0_cpu_debug_ocimem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] address,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  output logic [31:0]   readdata,
  output logic          waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JRD  = 2'd1,  // JTAG read in flight
    CRD  = 2'd2   // CPU read in flight
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_q;
  logic [AW-1:0] MonAReg;

  // JTAG strobe captured while a CPU read is completing; replayed next cycle.
  logic          pend_valid;
  logic          pend_a, pend_na, pend_b;
  logic [35:3]   pend_jdo;

  // Effective strobe set seen by the IDLE state (live or replayed).
  logic          use_pend;
  logic          eff_a, eff_na, eff_b, eff_any;
  logic [35:3]   eff_jdo;
  logic [1:0]    eff_cnt;
  logic          live_any;
  logic          collide;
  logic [AW-1:0] jtag_addr;
  logic [AW-1:0] inc_addr;

  // Decoded actions for this cycle.
  logic          do_a, do_na, do_b;
  logic          err_set;
  logic          cpu_wr;
  logic          pend_load;
  logic [AW-1:0] rd_addr;

  // Memory write port, shared by JTAG word writes and CPU byte writes.
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  // jdo bits that carry nothing for this block.
  logic          unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign live_any  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign use_pend  = (state_q == IDLE) && pend_valid;
  assign eff_a     = use_pend ? pend_a  : take_action_ocimem_a;
  assign eff_na    = use_pend ? pend_na : take_no_action_ocimem_a;
  assign eff_b     = use_pend ? pend_b  : take_action_ocimem_b;
  assign eff_jdo   = use_pend ? pend_jdo : jdo[35:3];
  assign eff_any   = eff_a | eff_na | eff_b;
  assign eff_cnt   = {1'b0, eff_a} + {1'b0, eff_na} + {1'b0, eff_b};
  // A live strobe landing on the replay cycle is a collision and is dropped.
  assign collide   = (eff_cnt > 2'd1) || (use_pend && live_any);
  assign jtag_addr = eff_jdo[AW+25:26];
  // AW = log2(DEPTH), so the natural AW-bit overflow is the DEPTH-1 -> 0 wrap.
  assign inc_addr  = MonAReg + AW'(1);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rd_addr     = address;
    do_a        = 1'b0;
    do_na       = 1'b0;
    do_b        = 1'b0;
    err_set     = 1'b0;
    cpu_wr      = 1'b0;
    pend_load   = 1'b0;
    waitrequest = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (eff_any) begin
          err_set     = collide;
          waitrequest = read | write;
          if (eff_a) begin
            do_a    = 1'b1;
            rd_addr = jtag_addr;
            if (eff_jdo[35]) state_d = JRD;
          end else if (eff_na) begin
            do_na   = 1'b1;
            rd_addr = inc_addr;
            state_d = JRD;
          end else begin
            do_b = 1'b1;
          end
        end else if (write) begin
          cpu_wr = 1'b1;
        end else if (read) begin
          waitrequest = 1'b1;
          state_d     = CRD;
        end
      end
      JRD: begin
        waitrequest = read | write;
        err_set     = live_any;
        state_d     = IDLE;
      end
      CRD: begin
        // The read data is already in ram_q, so the CPU read always finishes
        // here; a JTAG strobe is parked and replayed on the next cycle.
        waitrequest = write;
        pend_load   = live_any;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reset) waitrequest = read | write;
  end

  assign mem_we    = (do_b | cpu_wr) & ~reset;
  assign mem_waddr = do_b ? MonAReg : address;
  assign mem_wdata = do_b ? eff_jdo[34:3] : writedata;
  assign mem_be    = do_b ? 4'hF : byteenable;

  // NOTE: the RAM array has no reset; clearing it would prevent mapping onto
  // block RAM, and its contents must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ram_q <= '0;
    else       ram_q <= mem[rd_addr];
  end

  assign readdata = ram_q;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      pend_valid    <= 1'b0;
      pend_a        <= 1'b0;
      pend_na       <= 1'b0;
      pend_b        <= 1'b0;
      pend_jdo      <= '0;
    end else begin
      state_q <= state_d;

      if (do_a) begin
        MonAReg       <= jtag_addr;
        monitor_ready <= 1'b0;
      end
      if (do_na || do_b) MonAReg <= inc_addr;
      if (do_na) monitor_ready <= 1'b0;

      if (state_q == JRD) begin
        MonDReg       <= ram_q;
        monitor_ready <= 1'b1;
      end

      // A collision in the same cycle as a clear request still flags.
      if (err_set)                  monitor_error <= 1'b1;
      else if (do_a && eff_jdo[25]) monitor_error <= 1'b0;

      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_a     <= take_action_ocimem_a;
        pend_na    <= take_no_action_ocimem_a;
        pend_b     <= take_action_ocimem_b;
        pend_jdo   <= jdo[35:3];
      end else if (use_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_challengeqsys_nios2_gen2_0_cpu_debug_ocimem.sv
// ---------------------------------------------------------------------------
// Testbench for challengeqsys_nios2_gen2_0_cpu_debug_ocimem.
// Directed scenarios followed by random JTAG/CPU traffic. A word-array model
// of the RAM and MonAReg produces expected read data into two queues; a
// monitor pops and compares whenever the DUT presents CPU read data or a
// fresh MonDReg.
// ---------------------------------------------------------------------------
module tb_challengeqsys_nios2_gen2_0_cpu_debug_ocimem;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_no_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic [31:0]   MonDReg;
  logic          monitor_ready;
  logic          monitor_error;

  always #5 clk = ~clk;

  challengeqsys_nios2_gen2_0_cpu_debug_ocimem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [31:0] mem_m [DEPTH];
  int          mon_a = 0;
  bit          err_m = 1'b0;
  logic [31:0] cpu_q  [$];
  logic [31:0] jtag_q [$];
  bit          prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && read && !waitrequest) begin
      if (cpu_q.size() == 0) fail_now("cpu_read_unexpected");
      else check("cpu_readdata", readdata, cpu_q.pop_front());
    end
    if (monitor_ready && !prev_ready) begin
      if (jtag_q.size() == 0) fail_now("monitor_ready_unexpected");
      else check("MonDReg", MonDReg, jtag_q.pop_front());
    end
    prev_ready = monitor_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  function automatic logic [37:0] jdo_a(input int addr, input bit rd, input bit clr);
    logic [37:0] j;
    j        = 38'({$urandom, $urandom});
    j[35]    = rd;
    j[33:26] = addr[7:0];
    j[25]    = clr;
    return j;
  endfunction

  // action_a: load address, optional read (occupies 2 cycles if reading)
  task automatic jtag_a(input int addr, input bit rd, input bit clr);
    jdo = jdo_a(addr, rd, clr);
    take_action_ocimem_a = 1'b1;
    mon_a = addr;
    if (clr) err_m = 1'b0;
    if (rd) jtag_q.push_back(mem_m[addr]);
    tick();
    clear_strobes();
    if (rd) tick();
  endtask

  task automatic jtag_next();
    jdo = 38'({$urandom, $urandom});
    take_no_action_ocimem_a = 1'b1;
    mon_a = (mon_a + 1) % DEPTH;
    jtag_q.push_back(mem_m[mon_a]);
    tick();
    clear_strobes();
    tick();
  endtask

  task automatic jtag_write(input logic [31:0] data);
    jdo = 38'({$urandom, $urandom});
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    mem_m[mon_a] = data;
    mon_a = (mon_a + 1) % DEPTH;
    tick();
    clear_strobes();
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d, input logic [3:0] be);
    int waits = 0;
    bit done  = 1'b0;
    address = a[AW-1:0]; writedata = d; byteenable = be; write = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (!waitrequest) done = 1'b1;
      else begin waits++; tick(); end
    end
    if (!done) fail_now("cpu_write_timeout");
    check("cpu_write_waits", waits, 0);
    for (int i = 0; i < 4; i++)
      if (be[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
    tick();
    write = 1'b0;
  endtask

  // CPU read; optionally fire a JTAG action_a read in the same first cycle.
  task automatic cpu_read(input int a, input bit fire, input int jaddr, input int exp_waits);
    int waits = 0;
    bit done  = 1'b0;
    address = a[AW-1:0]; read = 1'b1;
    if (fire) begin
      jdo = jdo_a(jaddr, 1'b1, 1'b0);
      take_action_ocimem_a = 1'b1;
      mon_a = jaddr;
      jtag_q.push_back(mem_m[jaddr]);
    end
    cpu_q.push_back(mem_m[a]);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (!waitrequest) done = 1'b1;
      else begin waits++; tick(); clear_strobes(); end
    end
    if (!done) fail_now("cpu_read_timeout");
    check("cpu_read_waits", waits, exp_waits);
    tick();
    read = 1'b0;
    clear_strobes();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          old_a;

    reset = 1'b1; jdo = '0; clear_strobes();
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;

    // Strobes during reset must be ignored (a+b together would set error).
    tick();
    take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
    jdo = jdo_a(3, 1'b1, 1'b0);
    tick();
    clear_strobes();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_monitor_ready", 32'(monitor_ready), 32'h0);
    check("rst_monitor_error", 32'(monitor_error), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_waitrequest", 32'(waitrequest), 32'h0);
    tick();

    // Fill the whole RAM through JTAG streaming writes (wraps back to 0).
    jtag_a(0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) jtag_write($urandom);
    jtag_next();  // MonAReg wrapped to 0, so this reads RAM[1]

    // JTAG write/read at 0x10
    jtag_a(16, 1'b0, 1'b0);
    jtag_write(32'hDEADBEEF);
    jtag_a(16, 1'b1, 1'b0);
    @(negedge clk);
    check("jtag_rd_MonDReg", MonDReg, 32'hDEADBEEF);
    check("jtag_rd_ready", 32'(monitor_ready), 32'h1);
    jtag_next();  // MonAReg was 0x10 -> reads 0x11

    // Streaming wrap from 0xFF
    jtag_a(255, 1'b0, 1'b0);
    jtag_next();

    // Byte-lane write, then CPU read with one wait state
    cpu_write(5, 32'hAABBCCDD, 4'hF);
    cpu_write(5, 32'h11223344, 4'b0101);
    cpu_read(5, 1'b0, 0, 1);

    // CPU read held across a JTAG read: JRD then CRD
    cpu_read(9, 1'b1, 20, 3);

    // Simultaneous action_a and action_b: error, b dropped
    old_a = mon_a;
    jdo = jdo_a(30, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
    tick();
    clear_strobes();
    mon_a = 30; err_m = 1'b1;
    @(negedge clk);
    check("collide_error", 32'(monitor_error), 32'(err_m));
    tick();
    jtag_a(old_a, 1'b1, 1'b0);
    jtag_a(30, 1'b1, 1'b0);
    @(negedge clk);
    check("error_sticky", 32'(monitor_error), 32'(err_m));
    tick();
    jtag_a(30, 1'b0, 1'b1);
    @(negedge clk);
    check("error_cleared", 32'(monitor_error), 32'(err_m));
    tick();

    // Strobe during JRD: error, ignored
    jdo = jdo_a(40, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    mon_a = 40; jtag_q.push_back(mem_m[40]);
    tick();
    clear_strobes();
    jdo[34:3] = 32'h0BAD0BAD; take_action_ocimem_b = 1'b1;
    tick();
    clear_strobes();
    err_m = 1'b1;
    @(negedge clk);
    check("jrd_strobe_error", 32'(monitor_error), 32'(err_m));
    tick();
    jtag_a(40, 1'b1, 1'b1);

    // JTAG write landing in CRD is deferred, not dropped, no error
    d = $urandom;
    cpu_q.push_back(mem_m[7]);
    address = 8'd7; read = 1'b1;
    @(negedge clk);
    check("crd_first_wait", 32'(waitrequest), 32'h1);
    tick();
    jdo = 38'({$urandom, $urandom}); jdo[34:3] = d; take_action_ocimem_b = 1'b1;
    @(negedge clk);
    check("crd_completes", 32'(waitrequest), 32'h0);
    tick();
    read = 1'b0; clear_strobes();
    tick();
    mem_m[mon_a] = d; old_a = mon_a; mon_a = (mon_a + 1) % DEPTH;
    @(negedge clk);
    check("crd_defer_no_error", 32'(monitor_error), 32'(err_m));
    tick();
    jtag_a(old_a, 1'b1, 1'b0);

    // Reset pulsed the cycle after a JTAG read strobe
    jdo = jdo_a(50, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();
    clear_strobes();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mon_a = 0; err_m = 1'b0;
    @(negedge clk);
    check("midrst_MonDReg", MonDReg, 32'h0);
    check("midrst_ready", 32'(monitor_ready), 32'h0);
    tick();
    cpu_read(50, 1'b0, 0, 1);
    jtag_a(50, 1'b1, 1'b0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0: jtag_a($urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1: jtag_next();
        2: jtag_write($urandom);
        3: cpu_write($urandom_range(0, DEPTH-1), $urandom, 4'($urandom_range(0, 15)));
        4: cpu_read($urandom_range(0, DEPTH-1), 1'b0, 0, 1);
        default: cpu_read($urandom_range(0, DEPTH-1), 1'b1, $urandom_range(0, DEPTH-1), 3);
      endcase
    end

    repeat (3) tick();
    @(negedge clk);
    check("final_error", 32'(monitor_error), 32'(err_m));
    check("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    check("jtag_q_drained", 32'(jtag_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
